// File: rtl/psec5_serial_pkg.sv
// Shared types for the PSEC5 slow-control serializer: FSM state encoding and bit-counter sizing.
package psec5_serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } ser_state_t;

  // Wide enough to hold 0..width without wrapping.
  function automatic int unsigned ser_cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-index up-counter for one frame: clear, enable, and a flag when the last data bit is on the line.
module ser_bit_counter
  import psec5_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CW = ser_cnt_width(WIDTH)
) (
  input  logic          sclk,
  input  logic          rstn,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] count_o,
  output logic          tc_o
);

  logic [CW-1:0] count_q, count_d;

  assign tc_o    = (count_q == CW'(WIDTH - 1));
  assign count_o = count_q;

  // Holds at the terminal value so the index never wraps inside a frame.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && !tc_o) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with valid/ready intake, gap-free back-to-back frames and done strobe.
// Define SERIALIZER_PARITY_EN to append one parity bit (XOR of the word, XOR PARITY_ODD) to each frame.
module piso_serializer
  import psec5_serial_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic             sclk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             serial_out,
  output logic             frame,
  output logic             done
);

  localparam int unsigned CW = ser_cnt_width(WIDTH);

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             serial_q, serial_d;
  logic             frame_q, frame_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt;
  logic             cnt_tc, cnt_clr, cnt_en;
  logic             last_data, final_bit, accept;
  logic             first_bit, next_bit;

  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .sclk    (sclk),
    .rstn    (rstn),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (cnt),
    .tc_o    (cnt_tc)
  );

  assign last_data = (state_q == SHIFT) && cnt_tc;

`ifdef SERIALIZER_PARITY_EN
  logic parity_q;

  assign final_bit = (state_q == PARITY);

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      parity_q <= 1'b0;
    end else if (accept) begin
      parity_q <= (^din) ^ PARITY_ODD;
    end
  end
`else
  // Parity sense only matters when the parity stage is built.
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;

  assign final_bit = last_data;
`endif

  assign din_ready = (state_q == IDLE) || final_bit;
  assign accept    = din_valid && din_ready;
  assign first_bit = LSB_FIRST ? din[0] : din[WIDTH-1];
  assign next_bit  = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    serial_d = IDLE_LEVEL;
    frame_d  = 1'b0;
    done_d   = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    if (accept) begin
      // First bit goes straight to the line; the rest wait in the shift register.
      state_d  = SHIFT;
      serial_d = first_bit;
      sreg_d   = LSB_FIRST ? (din >> 1) : (din << 1);
      frame_d  = 1'b1;
      cnt_clr  = 1'b1;
    end else begin
      case (state_q)
        SHIFT: begin
          if (!cnt_tc) begin
            serial_d = next_bit;
            sreg_d   = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);
            frame_d  = 1'b1;
            cnt_en   = 1'b1;
`ifndef SERIALIZER_PARITY_EN
            done_d   = (cnt == CW'(WIDTH - 2));
`endif
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_d  = PARITY;
            serial_d = parity_q;
            frame_d  = 1'b1;
            done_d   = 1'b1;
`else
            state_d  = IDLE;
            cnt_clr  = 1'b1;
`endif
          end
        end
        PARITY: begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      serial_q <= IDLE_LEVEL;
      frame_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      serial_q <= serial_d;
      frame_q  <= frame_d;
      done_q   <= done_d;
    end
  end

  assign serial_out = serial_q;
  assign frame      = frame_q;
  assign done       = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first (idle 0) and MSB-first (idle 1) instances on one clock.
module tb_piso_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       sclk;
  logic       rstn;
  logic [7:0] din_a, din_b;
  logic       vld_a, vld_b;
  logic       rdy_a, rdy_b;
  logic       so_a, so_b;
  logic       fr_a, fr_b;
  logic       dn_a, dn_b;

  int n_cmp;
  int n_err;

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .PARITY_ODD(1'b0)) dut_a (
    .sclk(sclk), .rstn(rstn), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .serial_out(so_a), .frame(fr_a), .done(dn_a)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1), .PARITY_ODD(1'b0)) dut_b (
    .sclk(sclk), .rstn(rstn), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .serial_out(so_b), .frame(fr_b), .done(dn_b)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // {serial_out, frame, done, din_ready} of the selected instance (0 = LSB-first, 1 = MSB-first).
  function automatic logic [3:0] obs(input bit sel);
    return sel ? {so_b, fr_b, dn_b, rdy_b} : {so_a, fr_a, dn_a, rdy_a};
  endfunction

  function automatic logic idle_lvl(input bit sel);
    return sel ? 1'b1 : 1'b0;
  endfunction

  // Bit i of a frame carrying word w; index 8 is the even-parity bit.
  function automatic logic exp_bit(input bit sel, input logic [7:0] w, input int i);
    if (i == 8) return ^w;
    return sel ? w[7 - i] : w[i];
  endfunction

  task automatic test_reset;
    logic [3:0] oa, ob;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge sclk);
      vld_a = ~vld_a; vld_b = ~vld_b;
      din_a = 8'($urandom); din_b = 8'($urandom);
      #1;
      oa = obs(1'b0); ob = obs(1'b1);
      n_cmp++; if (oa[3:1] !== 3'b000) begin n_err++; $display("FAIL reset_a cyc%0d: {serial,frame,done}=%b expected 000", c, oa[3:1]); end
      n_cmp++; if (ob[3:1] !== 3'b100) begin n_err++; $display("FAIL reset_b cyc%0d: {serial,frame,done}=%b expected 100", c, ob[3:1]); end
    end
    vld_a = 1'b0; vld_b = 1'b0;
    @(negedge sclk); rstn = 1'b1;
    @(negedge sclk);
    oa = obs(1'b0); ob = obs(1'b1);
    n_cmp++; if (oa !== 4'b0001) begin n_err++; $display("FAIL release_a: {serial,frame,done,ready}=%b expected 0001", oa); end
    n_cmp++; if (ob !== 4'b1001) begin n_err++; $display("FAIL release_b: {serial,frame,done,ready}=%b expected 1001", ob); end
  endtask

  task automatic test_single_frame(input bit sel, input logic [7:0] w, input string tag);
    logic [3:0] o;
    logic       e;
    logic       last;
    @(negedge sclk);
    if (sel) begin din_b = w; vld_b = 1'b1; end else begin din_a = w; vld_a = 1'b1; end
    o = obs(sel);
    n_cmp++; if (o[0] !== 1'b1) begin n_err++; $display("FAIL %s pre_ready: din_ready=%b expected 1", tag, o[0]); end
    @(negedge sclk);
    // Scramble din after the accept edge: it must not be sampled again.
    if (sel) begin din_b = ~w; vld_b = 1'b0; end else begin din_a = ~w; vld_a = 1'b0; end
    for (int i = 0; i < FLEN; i++) begin
      if (i > 0) @(negedge sclk);
      o = obs(sel);
      e = exp_bit(sel, w, i);
      last = (i == FLEN - 1);
      n_cmp++; if (o[3] !== e) begin n_err++; $display("FAIL %s bit%0d: serial_out=%b expected %b", tag, i, o[3], e); end
      n_cmp++; if (o[2] !== 1'b1) begin n_err++; $display("FAIL %s frame%0d: frame=%b expected 1", tag, i, o[2]); end
      n_cmp++; if (o[1] !== last) begin n_err++; $display("FAIL %s done%0d: done=%b expected %b", tag, i, o[1], last); end
      n_cmp++; if (o[0] !== last) begin n_err++; $display("FAIL %s ready%0d: din_ready=%b expected %b", tag, i, o[0], last); end
    end
    @(negedge sclk);
    o = obs(sel);
    n_cmp++; if (o !== {idle_lvl(sel), 3'b001}) begin n_err++; $display("FAIL %s idle: {serial,frame,done,ready}=%b expected %b", tag, o, {idle_lvl(sel), 3'b001}); end
  endtask

  task automatic test_back_to_back;
    logic [3:0] o;
    logic [7:0] w;
    logic       e;
    logic       last;
    int         j;
    @(negedge sclk);
    din_a = 8'h0F; vld_a = 1'b1;
    @(negedge sclk);
    din_a = 8'hF0;
    for (int i = 0; i < 2 * FLEN; i++) begin
      if (i > 0) @(negedge sclk);
      if (i == FLEN) din_a = 8'h55;
      o = obs(1'b0);
      w = (i < FLEN) ? 8'h0F : 8'hF0;
      j = i % FLEN;
      e = exp_bit(1'b0, w, j);
      last = (j == FLEN - 1);
      n_cmp++; if (o[3] !== e) begin n_err++; $display("FAIL b2b bit%0d: serial_out=%b expected %b", i, o[3], e); end
      n_cmp++; if (o[2] !== 1'b1) begin n_err++; $display("FAIL b2b frame%0d: frame=%b expected 1", i, o[2]); end
      n_cmp++; if (o[1] !== last) begin n_err++; $display("FAIL b2b done%0d: done=%b expected %b", i, o[1], last); end
      n_cmp++; if (o[0] !== last) begin n_err++; $display("FAIL b2b ready%0d: din_ready=%b expected %b", i, o[0], last); end
      if (i == 2 * FLEN - 1) vld_a = 1'b0;
    end
    @(negedge sclk);
    o = obs(1'b0);
    n_cmp++; if (o !== 4'b0001) begin n_err++; $display("FAIL b2b idle: {serial,frame,done,ready}=%b expected 0001", o); end
  endtask

  task automatic test_reset_mid_frame;
    logic [3:0] o;
    @(negedge sclk);
    din_a = 8'hFF; vld_a = 1'b1;
    @(negedge sclk);
    vld_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge sclk);
      o = obs(1'b0);
      n_cmp++; if (o[3:2] !== 2'b11) begin n_err++; $display("FAIL midrst bit%0d: {serial,frame}=%b expected 11", i, o[3:2]); end
    end
    #2 rstn = 1'b0;
    #1;
    o = obs(1'b0);
    n_cmp++; if (o !== 4'b0001) begin n_err++; $display("FAIL midrst immediate: {serial,frame,done,ready}=%b expected 0001", o); end
    for (int c = 0; c < FLEN; c++) begin
      @(negedge sclk);
      if (c == FLEN - 1) rstn = 1'b1;
      o = obs(1'b0);
      n_cmp++; if (o[3:1] !== 3'b000) begin n_err++; $display("FAIL midrst hold%0d: {serial,frame,done}=%b expected 000", c, o[3:1]); end
    end
    test_single_frame(1'b0, 8'h3C, "post_rst_3c");
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity;
    logic [7:0] words [2];
    logic       par [2];
    logic [3:0] o;
    words[0] = 8'h07; par[0] = 1'b1;
    words[1] = 8'h03; par[1] = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge sclk);
      din_a = words[n]; vld_a = 1'b1;
      @(negedge sclk);
      vld_a = 1'b0;
      repeat (8) @(negedge sclk);
      o = obs(1'b0);
      n_cmp++; if (o !== {par[n], 3'b111}) begin n_err++; $display("FAIL parity%0d: {serial,frame,done,ready}=%b expected %b", n, o, {par[n], 3'b111}); end
      @(negedge sclk);
      o = obs(1'b0);
      n_cmp++; if (o[2:1] !== 2'b00) begin n_err++; $display("FAIL parity%0d end: {frame,done}=%b expected 00", n, o[2:1]); end
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    rstn  = 1'b1;
    din_a = 8'h00; din_b = 8'h00;
    vld_a = 1'b0;  vld_b = 1'b0;
    test_reset;
    test_single_frame(1'b0, 8'hA5, "lsb_a5");
    test_single_frame(1'b0, 8'h01, "lsb_01");
    test_single_frame(1'b1, 8'hA5, "msb_a5");
    test_single_frame(1'b1, 8'h01, "msb_01");
    test_back_to_back;
    test_reset_mid_frame;
`ifdef SERIALIZER_PARITY_EN
    test_parity;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out shifter for the PSEC5 slow-control path. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it onto a single serial line on sclk. It supports selectable bit order, a defined idle level, frame and done strobes, and gap-free back-to-back words. It replaces the fixed 8-bit, LSB-only, free-running shifter used for address words.

## Interface
Parameters:
- WIDTH, 8: data bits per word; legal values are ≥ 2.
- LSB_FIRST, 1: 1 shifts bit 0 first; 0 shifts bit WIDTH-1 first.
- IDLE_LEVEL, 0: serial_out level when no frame is active.
- PARITY_ODD, 0: parity sense, used only with SERIALIZER_PARITY_EN.

Ports:
- sclk  in  1  serial clock; all state updates on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- din  in  WIDTH  parallel word.
- din_valid  in  1  word available.
- din_ready  out  1  block can accept a word this cycle.
- serial_out  out  1  serial data, registered.
- frame  out  1  high while serial_out carries a frame bit, registered.
- done  out  1  high during the cycle carrying the final bit of a frame, registered.

## Operation
- Reset: it is asynchronous, active-low, on rstn, with clock sclk.
  - On reset: state=IDLE, serial_out=IDLE_LEVEL, frame=0, done=0, counter=0, shift register=0.
  - din_ready=1 after reset release.
- States:
  - IDLE: serial_out=IDLE_LEVEL; din_ready=1.
  - SHIFT: emitting data bits; the counter counts 0..WIDTH-1.
  - PARITY: exists only when the macro is defined.
- Accept: a word is taken on a rising edge with din_valid && din_ready. din is sampled only on that edge.
- On accept:
  - serial_out takes the first bit (din[0] if LSB_FIRST, else din[WIDTH-1]).
  - The remaining bits load into the shift register.
  - frame=1, counter=0, state goes to SHIFT.
- SHIFT: each edge, serial_out takes the next bit and the counter increments.
- din_ready is combinational:
  - 1 in IDLE.
  - 1 during the final bit cycle of a frame (last data bit, or the parity bit when enabled).
  - 0 otherwise.
- Back-to-back: an accept during the final bit cycle starts the next frame's first bit on the following edge. frame stays 1, with no idle gap.
- End of frame with no new accept: the next edge returns to IDLE, sets serial_out=IDLE_LEVEL and frame=0.
- done: registered and coincident with the final bit on serial_out. It is exactly one cycle per frame, including back-to-back frames.
- din_valid deasserted mid-frame has no effect. There is no abort input.
- Counter width is $clog2(WIDTH+1). The counter never wraps within a frame.

## Timing
- Accept edge k puts bit 0 of the frame on serial_out after edge k. Bit i appears after edge k+i.
- Data occupies cycles k .. k+WIDTH-1. With parity, the parity bit follows at k+WIDTH.
- Frame length is WIDTH cycles, or WIDTH+1 with parity.
- done is high in the cycle after edge k+WIDTH-1, or k+WIDTH with parity.
- Sustained throughput is one word per WIDTH (or WIDTH+1) cycles.
- Reset asserted mid-frame:
  - Outputs go to their reset values immediately.
  - The partial frame is discarded and no done is issued.
  - din_ready=1 after release.

## Configuration
- Macro: SERIALIZER_PARITY_EN.
- Defined:
  - A PARITY state follows SHIFT and emits one parity bit over the accepted word. The bit is the XOR of all bits, XOR PARITY_ODD.
  - Parity is computed and registered at accept.
  - frame covers the parity bit, and done and the end-of-frame din_ready move to the parity cycle.
- Undefined: there is no PARITY state, frame is WIDTH bits, and PARITY_ODD is ignored.

## Structure
- Shared package psec5_serial_pkg holds:
  - The state enum typedef (ser_state_t: IDLE, SHIFT, PARITY).
  - A localparam function computing the counter width.
- One sub-module, ser_bit_counter. It is a parametrised up-counter with clear, enable and a terminal-count flag, and drives the final-bit decision.
- The top level holds the FSM, the shift register and the output registers.

## Test plan
- **Reset:** Hold rstn=0 with din_valid=1 toggling.
  - Expect serial_out=IDLE_LEVEL, frame=0, done=0.
  - Expect din_ready=1 after release.
- **LSB-first:** WIDTH=8, LSB_FIRST=1, single word 0xA5.
  - Expect serial_out 1,0,1,0,0,1,0,1 on cycles k..k+7.
  - Expect frame high for 8 cycles and done only at k+7, then idle.
- **MSB-first:** LSB_FIRST=0, word 0xA5.
  - Expect 1,0,1,0,0,1,0,1 reversed order from din[7], i.e. 1,0,1,0,0,1,0,1 read MSB down.
  - Check a second word 0x01, which must give 0,0,0,0,0,0,0,1.
- **Back-to-back:** Send 0x0F then 0xF0 with din_valid held high.
  - Expect 16 contiguous frame cycles and no idle bit.
  - Expect done at k+7 and k+15, and din_ready high only at k+7 and k+15.
- **Reset mid-frame:** Pull rstn low after the 3rd bit of 0xFF.
  - Expect immediate serial_out=IDLE_LEVEL and no done.
  - A subsequent word 0x3C must serialise correctly.
- **Parity:** With SERIALIZER_PARITY_EN, PARITY_ODD=0, word 0x07.
  - Expect parity bit 1 at k+8, frame length 9, done at k+8.
  - Repeat with word 0x03, which must give parity bit 0.
